// File: rtl/tri_vertex_projector_if.sv
// tri_vertex_projector_if: triangle in/out handshake bundle.
// master drives triangles in and takes results; slave is the projector.
interface tri_vertex_projector_if;
  logic         in_valid;
  logic         in_ready;
  logic [287:0] in_tri;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] out_tri;

  modport master (
    output in_valid, in_tri, out_ready,
    input  in_ready, out_valid, out_tri
  );

  modport slave (
    input  in_valid, in_tri, out_ready,
    output in_ready, out_valid, out_tri
  );
endinterface

// File: rtl/tri_vertex_projector.sv
// tri_vertex_projector: (coord*FOCAL)/z + offset, clamped to the raster.
// TRI_PERSPECTIVE_EN builds the multiplier/divider; otherwise offset+clamp only.
module tri_vertex_projector #(
  parameter int FOCAL = 300,
  parameter int X_OFF = 320,
  parameter int Y_OFF = 240,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479
) (
  input  logic                 clk,
  input  logic                 reset,
  tri_vertex_projector_if.slave bus,
  output logic                 busy,
  output logic                 div_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    STORE,
    DONE
  } state_t;

  localparam logic signed [65:0] W_XO   = 66'(X_OFF);
  localparam logic signed [65:0] W_YO   = 66'(Y_OFF);
  localparam logic signed [65:0] W_XMAX = 66'(XMAX);
  localparam logic signed [65:0] W_YMAX = 66'(YMAX);

  state_t       r_state;
  logic         r_ovalid;
  logic         r_err;
  logic [191:0] r_out;

  function automatic logic [31:0] clamp(
    input logic signed [65:0] v,
    input logic signed [65:0] hi
  );
    logic [31:0] res;
    res = v[31:0];
    if (v < 66'sd0) res = '0;
    else if (v > hi) res = hi[31:0];
    return res;
  endfunction

  assign bus.in_ready  = (r_state == IDLE) && reset;
  assign bus.out_valid = r_ovalid;
  assign bus.out_tri   = r_out;
  assign busy          = (r_state != IDLE);
  assign div_err       = r_err;

`ifdef TRI_PERSPECTIVE_EN

  localparam logic signed [63:0] W_FOC = 64'(FOCAL);

  logic [31:0] r_tri [9];
  logic [2:0]  r_c;
  logic [5:0]  r_cnt;
  logic [63:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg;

  logic [3:0]         w_xi;
  logic [3:0]         w_zi;
  logic signed [31:0] w_coord;
  logic signed [31:0] w_z;
  logic signed [63:0] w_num;
  logic [63:0]        w_nmag;
  logic [32:0]        w_sh;
  logic               w_ge;
  logic [32:0]        w_diff;
  logic signed [65:0] w_sq;
  logic signed [65:0] w_sum;
  logic [31:0]        w_word;

  // word c of the output comes from vertex c/2, component c%2
  assign w_xi = 4'({r_c[2:1], 1'b0}) + 4'(r_c[2:1]) + 4'(r_c[0]);
  assign w_zi = 4'({r_c[2:1], 1'b0}) + 4'(r_c[2:1]) + 4'd2;

  assign w_coord = r_tri[w_xi];
  assign w_z     = r_tri[w_zi];
  assign w_num   = 64'(w_coord) * W_FOC;
  assign w_nmag  = w_num[63] ? 64'(-w_num) : 64'(w_num);

  // remainder stays below the divisor (< 2^31), so 32 bits hold it
  assign w_sh   = {r_rem, r_quo[63]};
  assign w_ge   = (w_sh >= {1'b0, r_div});
  assign w_diff = w_sh - {1'b0, r_div};

  assign w_sq   = r_neg ? -$signed({2'b00, r_quo})
                        :  $signed({2'b00, r_quo});
  assign w_sum  = w_sq + (r_c[0] ? W_YO : W_XO);
  assign w_word = clamp(w_sum, r_c[0] ? W_YMAX : W_XMAX);

  // control FSM with shared multiplier and restoring divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
      r_out    <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg    <= 1'b0;
      for (int k = 0; k < 9; k++) r_tri[k] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < 9; k++)
              r_tri[k] <= bus.in_tri[32*k +: 32];
            r_err   <= 1'b0;
            r_c     <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_neg <= w_coord[31] ^ w_z[31];
          r_rem <= '0;
          r_cnt <= '0;
          if (w_z <= 32'sd0) begin
            r_err <= 1'b1;
            r_quo <= '0;
            r_div <= 32'd1;
          end else begin
            r_quo <= w_nmag;
            r_div <= w_z;
          end
          r_state <= ITER;
        end
        ITER: begin
          r_rem <= w_ge ? w_diff[31:0] : w_sh[31:0];
          r_quo <= {r_quo[62:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) r_state <= STORE;
        end
        STORE: begin
          r_out[32*r_c +: 32] <= w_word;
          if (r_c < 3'd5) begin
            r_c     <= r_c + 3'd1;
            r_state <= LOAD;
          end else begin
            r_ovalid <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (!r_ovalid) begin
            r_ovalid <= 1'b1;
          end else if (bus.out_ready) begin
            r_ovalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`else

  logic [191:0] w_flat;
  logic         w_unused_z;

  // z words carry no meaning without the divider
  assign w_unused_z = ^{bus.in_tri[95:64],
                        bus.in_tri[191:160],
                        bus.in_tri[287:256]};

  // offset and clamp each x/y straight from the input bus
  always_comb begin
    w_flat = '0;
    for (int c = 0; c < 6; c++) begin
      w_flat[32*c +: 32] = clamp(
        66'($signed(bus.in_tri[32*(3*(c/2) + c%2) +: 32]))
          + ((c % 2) != 0 ? W_YO : W_XO),
        (c % 2) != 0 ? W_YMAX : W_XMAX);
    end
  end

  // accept, register the flat result, present it one edge later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
      r_out    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_out   <= w_flat;
            r_err   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!r_ovalid) begin
            r_ovalid <= 1'b1;
          end else if (bus.out_ready) begin
            r_ovalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_tri_vertex_projector.sv
// tb_tri_vertex_projector: directed vectors for tri_vertex_projector.
// Expected values follow TRI_PERSPECTIVE_EN when it is defined.
module tb_tri_vertex_projector;

`ifdef TRI_PERSPECTIVE_EN
  localparam bit PERSP = 1'b1;
  localparam int LAT   = 396;
`else
  localparam bit PERSP = 1'b0;
  localparam int LAT   = 1;
`endif

  typedef struct {
    string        nm;
    logic [287:0] tv;
    logic [191:0] ep;
    logic [191:0] ef;
    logic         ep_err;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic div_err;
  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t vecs[5];

  tri_vertex_projector_if u_if();

  tri_vertex_projector u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (u_if),
    .busy   (busy),
    .div_err(div_err)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] mk9(
    input int a, b, c, d, e, f, g, h, k
  );
    return {32'(k), 32'(h), 32'(g), 32'(f), 32'(e),
            32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [191:0] mk6(
    input int a, b, c, d, e, f
  );
    return {32'(f), 32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, $signed(act), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (u_if.out_valid !== 1'b1 && lat < 1000) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input int i);
    logic [191:0] e;
    e = PERSP ? vecs[i].ep : vecs[i].ef;
    for (int j = 0; j < 6; j++)
      chkw($sformatf("%s w%0d", vecs[i].nm, j),
           u_if.out_tri[32*j +: 32], e[32*j +: 32]);
    chk1({vecs[i].nm, " div_err"}, div_err, PERSP ? vecs[i].ep_err : 1'b0);
  endtask

  task automatic handshake(input string nm);
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    chk1({nm, " out_valid drop"}, u_if.out_valid, 1'b0);
    chk1({nm, " busy idle"}, busy, 1'b0);
  endtask

  task automatic run_vec(input int i);
    int lat;
    chk1({vecs[i].nm, " in_ready"}, u_if.in_ready, 1'b1);
    u_if.in_tri   = vecs[i].tv;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    wait_valid(lat);
    chkw({vecs[i].nm, " latency"}, 32'(lat), 32'(LAT));
    check_result(i);
    handshake(vecs[i].nm);
  endtask

  initial begin
    logic [191:0] snap;
    logic         stable;
    int           lat;

    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.in_tri    = '0;

    vecs[0] = '{"basic", mk9(100, 50, 300, -60, 30, 150, 0, 0, 600),
                mk6(420, 290, 200, 300, 320, 240),
                mk6(420, 290, 260, 270, 320, 240), 1'b0};
    vecs[1] = '{"trunc", mk9(-7, 7, 400, -60, 30, 150, 0, 0, 600),
                mk6(315, 245, 200, 300, 320, 240),
                mk6(313, 247, 260, 270, 320, 240), 1'b0};
    vecs[2] = '{"clamp", mk9(1000, -1000, 300, -1000, 1000, 300, 0, 0, 600),
                mk6(639, 0, 0, 479, 320, 240),
                mk6(639, 0, 0, 479, 320, 240), 1'b0};
    vecs[3] = '{"zzero", mk9(100, 50, 300, -60, 30, 0, 0, 0, 600),
                mk6(420, 290, 320, 240, 320, 240),
                mk6(420, 290, 260, 270, 320, 240), 1'b1};
    vecs[4] = '{"edges", mk9(319, 239, 300, -320, -240, 300, -321, -241, 300),
                mk6(639, 479, 0, 0, 0, 0),
                mk6(639, 479, 0, 0, 0, 0), 1'b0};

    repeat (2) tick();
    chk1("rst in_ready", u_if.in_ready, 1'b0);
    chk1("rst out_valid", u_if.out_valid, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst div_err", div_err, 1'b0);
    chk1("rst out_tri zero", |u_if.out_tri, 1'b0);

    reset = 1'b1;
    tick();
    chk1("post-rst in_ready", u_if.in_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // backpressure with a new triangle waiting
    u_if.in_tri   = vecs[0].tv;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    wait_valid(lat);
    chkw("bp latency", 32'(lat), 32'(LAT));
    u_if.in_tri   = vecs[2].tv;
    u_if.in_valid = 1'b1;
    snap   = u_if.out_tri;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (u_if.out_tri !== snap || u_if.in_ready !== 1'b0 ||
          u_if.out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk1("bp hold stable", stable, 1'b1);
    check_result(0);
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    chk1("bp out_valid drop", u_if.out_valid, 1'b0);
    chk1("bp idle in_ready", u_if.in_ready, 1'b1);
    tick();
    u_if.in_valid = 1'b0;
    chk1("bp new accepted busy", busy, 1'b1);
    chk1("bp new in_ready low", u_if.in_ready, 1'b0);
    wait_valid(lat);
    chkw("bp new latency", 32'(lat), 32'(LAT));
    check_result(2);
    handshake("bp new");

    // reset in the middle of a triangle
    u_if.in_tri   = vecs[3].tv;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    repeat (100) tick();
    reset = 1'b0;
    #1;
    chk1("midrst out_valid", u_if.out_valid, 1'b0);
    chk1("midrst busy", busy, 1'b0);
    chk1("midrst in_ready", u_if.in_ready, 1'b0);
    chk1("midrst div_err", div_err, 1'b0);
    chk1("midrst out_tri zero", |u_if.out_tri, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
